// File: rtl/cmp_hysteresis_monitor.sv
// cmp_hysteresis_monitor: debounced alarm with hysteresis on comparator flags.
// Emits rise/fall pulses, a saturating rise counter and a sticky format error.
module cmp_hysteresis_monitor #(
    parameter int CONFIRM_N = 3,
    parameter int CNT_W     = 4,
    parameter int EVT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             greater,
    input  logic             equal,
    input  logic             less,
    input  logic             clear,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             alarm_fall,
    output logic [CNT_W-1:0] streak,
    output logic [EVT_W-1:0] rise_count,
    output logic             err_flag
);

    typedef enum logic {
        S_LOW  = 1'b0,
        S_HIGH = 1'b1
    } state_t;

    localparam bit CFG_OK =
        (CONFIRM_N >= 1) && (CONFIRM_N <= (2 ** CNT_W) - 1);
    localparam logic [CNT_W-1:0] CONF    = CONFIRM_N[CNT_W-1:0];
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] streak_nxt;
    logic [CNT_W-1:0] streak_inc;
    logic             onehot;
    logic             malformed;
    logic             qual;
    logic             hit;
    logic             qual_step;
    logic             nonqual;
    logic             rise_ev;
    logic             fall_ev;

    // Classify the incoming sample against the current alarm level.
    always_comb begin
        onehot     = (greater ^ equal ^ less) & ~(greater & equal & less);
        malformed  = in_valid & ~onehot;
        qual       = in_valid & onehot &
                     ((state == S_LOW) ? greater : less);
        streak_inc = streak + CNT_W'(1);
        hit        = qual & (streak_inc == CONF);
        qual_step  = qual & ~hit;
        nonqual    = in_valid & onehot & ~qual;
    end

    // Next state, next streak and transition events.
    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        rise_ev    = 1'b0;
        fall_ev    = 1'b0;
        unique case (1'b1)
            malformed: begin
                state_nxt  = state;
                streak_nxt = streak;
            end
            hit: begin
                streak_nxt = '0;
                unique case (state)
                    S_LOW: begin
                        state_nxt = S_HIGH;
                        rise_ev   = 1'b1;
                    end
                    S_HIGH: begin
                        state_nxt = S_LOW;
                        fall_ev   = 1'b1;
                    end
                    default: state_nxt = S_LOW;
                endcase
            end
            qual_step: streak_nxt = streak_inc;
            nonqual:   streak_nxt = '0;
            default: begin
                state_nxt  = state;
                streak_nxt = streak;
            end
        endcase
    end

    // Alarm level state and confirmation streak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_LOW;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    // One-cycle edge pulses, registered alongside the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_rise <= 1'b0;
            alarm_fall <= 1'b0;
        end else begin
            alarm_rise <= rise_ev;
            alarm_fall <= fall_ev;
        end
    end

    // Saturating rise counter; clear takes priority over a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_count <= '0;
        end else if (clear) begin
            rise_count <= '0;
        end else if (rise_ev && rise_count != EVT_MAX) begin
            rise_count <= rise_count + EVT_W'(1);
        end
    end

    // Sticky error for non-one-hot valid flags; clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
        end else if (clear) begin
            err_flag <= 1'b0;
        end else if (malformed) begin
            err_flag <= 1'b1;
        end
    end

    // Out-of-range confirmation count is a configuration error.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cfg_range: assert (CFG_OK);
        end
    end

    assign alarm = (state == S_HIGH);

endmodule

// File: doc/cmp_hysteresis_monitor.md
Name: cmp_hysteresis_monitor

Overview:
Downstream consumer of the 4-bit magnitude comparator's greater/equal/less flags, where the comparator compares a sample against a threshold. It debounces the flag stream with a consecutive-sample confirmation counter and drives a registered alarm with hysteresis. It also produces rise and fall event pulses, a saturating rise-event counter, and a sticky error for malformed (non-one-hot) flag sets. It sits between the comparator and the status/interrupt logic.

Parameters:
CONFIRM_N, 3, consecutive qualifying valid samples required to change alarm state; legal range 1 to 2^CNT_W-1.
CNT_W, 4, width of the streak counter.
EVT_W, 8, width of the saturating rise-event counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  comparator flags are valid this cycle.
greater  input  1  comparator: sample > threshold.
equal  input  1  comparator: sample == threshold.
less  input  1  comparator: sample < threshold.
clear  input  1  synchronous clear of err_flag and rise_count.
alarm  output  1  registered alarm level.
alarm_rise  output  1  1-cycle pulse on alarm 0->1.
alarm_fall  output  1  1-cycle pulse on alarm 1->0.
streak  output  CNT_W  current consecutive-qualifying-sample count.
rise_count  output  EVT_W  saturating count of alarm rises.
err_flag  output  1  sticky: a valid sample had non-one-hot flags.

Behaviour:
- Reset: asserting rst_n low immediately forces state=S_LOW and sets alarm, alarm_rise, alarm_fall, streak, rise_count and err_flag to 0. This applies even mid-streak. The first update after release happens on the next rising clk edge.
- States: S_LOW (alarm=0) and S_HIGH (alarm=1). alarm is a registered function of state.
- Qualifying sample: in_valid=1, flags one-hot, and the flag is greater in S_LOW or less in S_HIGH.
- Qualifying sample, when streak+1 < CONFIRM_N: streak <= streak+1.
- Qualifying sample, when streak+1 == CONFIRM_N:
  - Toggle state and set streak <= 0.
  - Pulse alarm_rise (S_LOW->S_HIGH) or alarm_fall (S_HIGH->S_LOW) for exactly one cycle.
  - Latency: alarm changes on the same edge that consumes the CONFIRM_N-th qualifying sample, i.e. it is visible the cycle after that sample is presented.
- Non-qualifying valid one-hot sample: streak <= 0, state holds. This covers equal in either state, less in S_LOW, and greater in S_HIGH. equal therefore never advances the count.
- in_valid=0: streak, state and err_flag hold. Flags are ignored. Gaps do not break a streak.
- Malformed sample: in_valid=1 with greater+equal+less != 1, including all-zero.
  - err_flag <= 1 (sticky).
  - The sample is ignored: streak and state hold.
- rise_count increments by 1 on each S_LOW->S_HIGH transition and saturates at 2^EVT_W-1.
- clear=1 sets err_flag <= 0 and rise_count <= 0.
  - clear wins over a simultaneous malformed sample or rise event in the same cycle.
  - clear does not affect state, streak or alarm.
- alarm_rise and alarm_fall are never both 1. Both are 0 in every cycle without a transition.
- CONFIRM_N=1: the first qualifying sample switches state; streak stays 0.
- Width rule: streak compare uses CNT_W bits. Out-of-range CONFIRM_N is illegal; the implementation must flag it with a simulation-time check.

Test Plan:
1. CONFIRM_N=3; after reset apply valid greater for 3 consecutive cycles -> streak 1,2 after cycles 1,2; after the 3rd edge alarm=1, alarm_rise=1 for one cycle, streak=0, rise_count=1.
2. In S_LOW apply greater, greater, equal, greater, greater (all valid) -> alarm stays 0; streak reads 1,2,0,1,2.
3. Streak with gaps: greater, then in_valid=0 for 5 cycles, then greater, greater -> alarm rises after the final sample. Then 3 valid less samples -> alarm=0 with a one-cycle alarm_fall pulse; rise_count remains 1.
4. Malformed flags: valid with greater=1 and less=1 at streak=2 -> err_flag=1, streak stays 2. Next cycle clear=1 -> err_flag=0, rise_count=0, alarm unchanged.
5. Reset mid-operation: S_HIGH with streak=2, rst_n driven low between edges -> alarm, streak, rise_count and err_flag read 0 immediately, before the next clock edge.
6. EVT_W=2: drive 5 complete rise/fall cycles -> rise_count reads 1,2,3,3,3 (saturates at 3).
